// File: rtl/gas_pump_pkg.sv
// Shared definitions for the gas pump slice: meter and pump-controller state encodings
// and the default metering ratio.
package gas_pump_pkg;

    typedef enum logic [1:0] {
        MS_IDLE     = 2'b00,
        MS_DISPENSE = 2'b01,
        MS_DONE     = 2'b10
    } meter_state_e;

    typedef enum logic [1:0] {
        PUMP_S0         = 2'b00,
        PUMP_S1         = 2'b01,
        PUMP_S2_SHUTOFF = 2'b10
    } pump_state_e;

    localparam int unsigned DEFAULT_PULSES_PER_UNIT = 10;

endpackage

// File: rtl/fuel_dispense_meter_if.sv
// Bundle between the pump controller / display-payment logic and the dispense meter.
// The meter sits on the slave side.
interface fuel_dispense_meter_if #(
    parameter int unsigned VOL_W   = 16,
    parameter int unsigned PRICE_W = 8,
    parameter int unsigned TOTAL_W = 24
) ();
    logic               fuel_out;
    logic [1:0]         pump_state;
    logic [PRICE_W-1:0] price_per_unit;
    logic [VOL_W-1:0]   preset_volume;
    logic               start;
    logic               clear;
    logic [VOL_W-1:0]   volume;
    logic [TOTAL_W-1:0] amount_due;
    logic               dispense_enable;
    logic               txn_done;
    logic [1:0]         meter_state;

    modport master (
        output fuel_out, pump_state, price_per_unit, preset_volume, start, clear,
        input  volume, amount_due, dispense_enable, txn_done, meter_state
    );

    modport slave (
        input  fuel_out, pump_state, price_per_unit, preset_volume, start, clear,
        output volume, amount_due, dispense_enable, txn_done, meter_state
    );
endinterface

// File: rtl/unit_prescaler.sv
// Mod-PULSES_PER_UNIT counter of fuel_out-high cycles; unit_tick marks the cycle
// that completes a whole volume unit. clr has priority over en.
module unit_prescaler
    import gas_pump_pkg::*;
#(
    parameter int unsigned PULSES_PER_UNIT = DEFAULT_PULSES_PER_UNIT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic unit_tick
);
    localparam int unsigned CW = $clog2(PULSES_PER_UNIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    always_comb begin
        at_last   = (cnt_q == CW'(PULSES_PER_UNIT - 1));
        unit_tick = en && !clr && at_last;
        cnt_d     = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fuel_dispense_meter.sv
// Dispense meter: converts fuel_out cycles to whole units, accumulates the amount due,
// stops dispensing on shutoff, preset reached or volume saturation.
module fuel_dispense_meter
    import gas_pump_pkg::*;
#(
    parameter int unsigned PULSES_PER_UNIT = DEFAULT_PULSES_PER_UNIT,
    parameter int unsigned VOL_W           = 16,
    parameter int unsigned PRICE_W         = 8,
    parameter int unsigned TOTAL_W         = 24
) (
    input logic                  clk,
    input logic                  reset_n,
    fuel_dispense_meter_if.slave bus
);
    localparam int unsigned SUM_W = TOTAL_W + 1;

    meter_state_e       state_q, state_d;
    logic [VOL_W-1:0]   volume_q, volume_d;
    logic [TOTAL_W-1:0] amount_q, amount_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [VOL_W-1:0]   preset_q, preset_d;
    logic               txn_done_q, txn_done_d;

    logic               presc_en, presc_clr, unit_tick;
    logic [VOL_W-1:0]   vol_inc;
    logic [SUM_W-1:0]   amount_sum;
    logic [TOTAL_W-1:0] amount_inc;

    // Partial counts never survive outside DISPENSE, so a new transaction starts from zero.
    assign presc_en  = (state_q == MS_DISPENSE) && bus.fuel_out;
    assign presc_clr = bus.clear || (state_q != MS_DISPENSE);

    unit_prescaler #(
        .PULSES_PER_UNIT(PULSES_PER_UNIT)
    ) u_prescaler (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (presc_en),
        .clr       (presc_clr),
        .unit_tick (unit_tick)
    );

    always_comb begin
        vol_inc    = volume_q + VOL_W'(1);
        amount_sum = SUM_W'(amount_q) + SUM_W'(price_q);
        amount_inc = amount_sum[TOTAL_W] ? '1 : amount_sum[TOTAL_W-1:0];

        state_d    = state_q;
        volume_d   = volume_q;
        amount_d   = amount_q;
        price_d    = price_q;
        preset_d   = preset_q;

        if (bus.clear) begin
            state_d  = MS_IDLE;
            volume_d = '0;
            amount_d = '0;
        end else begin
            case (state_q)
                MS_IDLE, MS_DONE: begin
                    if (bus.start) begin
                        price_d  = bus.price_per_unit;
                        preset_d = bus.preset_volume;
                        volume_d = '0;
                        amount_d = '0;
                        state_d  = MS_DISPENSE;
                    end
                end
                MS_DISPENSE: begin
                    if (unit_tick) begin
                        volume_d = vol_inc;
                        amount_d = amount_inc;
                    end
                    if (bus.pump_state == PUMP_S2_SHUTOFF) begin
                        state_d = MS_DONE;
                    end else if (unit_tick && (preset_q != '0) && (vol_inc == preset_q)) begin
                        state_d = MS_DONE;
                    end else if (unit_tick && (vol_inc == '1)) begin
                        state_d = MS_DONE;
                    end
                end
                default: begin
                    state_d  = MS_IDLE;
                    volume_d = '0;
                    amount_d = '0;
                end
            endcase
        end

        txn_done_d = (state_d == MS_DONE) && (state_q != MS_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= MS_IDLE;
            volume_q   <= '0;
            amount_q   <= '0;
            price_q    <= '0;
            preset_q   <= '0;
            txn_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            volume_q   <= volume_d;
            amount_q   <= amount_d;
            price_q    <= price_d;
            preset_q   <= preset_d;
            txn_done_q <= txn_done_d;
        end
    end

    assign bus.volume          = volume_q;
    assign bus.amount_due      = amount_q;
    assign bus.dispense_enable = (state_q == MS_DISPENSE);
    assign bus.txn_done        = txn_done_q;
    assign bus.meter_state     = state_q;
endmodule

// File: tb/tb_fuel_dispense_meter.sv
// Bench for fuel_dispense_meter: directed scenarios plus randomized traffic checked
// against an arithmetic model (volume = pulses / ratio, amount = volume * price).
module tb_fuel_dispense_meter;
    localparam int unsigned P       = 10;
    localparam longint      VMAX    = 65535;
    localparam longint      AMT_MAX = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fuel_out, start, clear;
    logic [1:0]  pump_state;
    logic [7:0]  price;
    logic [15:0] preset;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int     m_st;
    longint m_pulses, m_vol, m_price, m_preset;
    bit     m_done;

    fuel_dispense_meter_if #(.VOL_W(16), .PRICE_W(8), .TOTAL_W(24)) b0 ();
    fuel_dispense_meter_if #(.VOL_W(4),  .PRICE_W(8), .TOTAL_W(12)) b1 ();

    assign b0.fuel_out       = fuel_out;
    assign b0.pump_state     = pump_state;
    assign b0.price_per_unit = price;
    assign b0.preset_volume  = preset;
    assign b0.start          = start;
    assign b0.clear          = clear;
    assign b1.fuel_out       = fuel_out;
    assign b1.pump_state     = pump_state;
    assign b1.price_per_unit = price;
    assign b1.preset_volume  = preset[3:0];
    assign b1.start          = start;
    assign b1.clear          = clear;

    fuel_dispense_meter #(
        .PULSES_PER_UNIT(P), .VOL_W(16), .PRICE_W(8), .TOTAL_W(24)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0)
    );

    fuel_dispense_meter #(
        .PULSES_PER_UNIT(P), .VOL_W(4), .PRICE_W(8), .TOTAL_W(12)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int prev;
        bit unit;
        unit = 1'b0;
        if (!reset_n) begin
            m_st = 0; m_pulses = 0; m_vol = 0; m_price = 0; m_preset = 0; m_done = 1'b0;
        end else begin
            prev = m_st;
            if (clear) begin
                m_st = 0; m_pulses = 0; m_vol = 0;
            end else if ((m_st == 0 || m_st == 2) && start) begin
                m_price = price; m_preset = preset; m_pulses = 0; m_vol = 0; m_st = 1;
            end else if (m_st == 1) begin
                if (fuel_out) begin
                    m_pulses++;
                    if (m_pulses % P == 0) begin
                        unit  = 1'b1;
                        m_vol = m_pulses / P;
                    end
                end
                if (pump_state == 2'b10) m_st = 2;
                else if (unit && m_preset != 0 && m_vol == m_preset) m_st = 2;
                else if (unit && m_vol == VMAX) m_st = 2;
            end
            m_done = (m_st == 2) && (prev != 2);
        end
    endtask

    function automatic longint model_amount();
        longint a;
        a = m_vol * m_price;
        return (a > AMT_MAX) ? AMT_MAX : a;
    endfunction

    // one clock: model consumes the inputs seen at the edge, outputs are sampled 1 ns later
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fuel_out = 1'b0; start = 1'b0; clear = 1'b0; pump_state = 2'b00;
    endtask

    task automatic begin_txn(input logic [7:0] pr, input logic [15:0] ps);
        idle_inputs();
        clear = 1'b1;
        step();
        clear = 1'b0; start = 1'b1; price = pr; preset = ps;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; price = '0; preset = '0;
        idle_inputs();
        step(); step();
        n_cmp++;
        if (b0.volume !== 16'd0 || b0.amount_due !== 24'd0 || b0.meter_state !== 2'b00 ||
            b0.dispense_enable !== 1'b0 || b0.txn_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: vol=%0d amt=%0d st=%b en=%b done=%b, want all 0",
                     b0.volume, b0.amount_due, b0.meter_state, b0.dispense_enable, b0.txn_done);
        end
        reset_n = 1'b1;
        begin_txn(8'd7, 16'd0);
        fuel_out = 1'b1;
        repeat (30) step();
        fuel_out = 1'b0;
        n_cmp++;
        if (b0.volume !== 16'd3) begin
            n_bad++;
            $display("FAIL reset_pre_vol: got %0d want 3", b0.volume);
        end
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (b0.volume !== 16'd0 || b0.amount_due !== 24'd0 || b0.meter_state !== 2'b00 ||
                b0.dispense_enable !== 1'b0 || b0.txn_done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid_txn[%0d]: vol=%0d amt=%0d st=%b en=%b done=%b, want all 0",
                         i, b0.volume, b0.amount_due, b0.meter_state, b0.dispense_enable, b0.txn_done);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_shutoff();
        begin_txn(8'd3, 16'd0);
        fuel_out = 1'b1;
        repeat (25) step();
        fuel_out = 1'b0; pump_state = 2'b10;
        step();
        pump_state = 2'b00;
        n_cmp++;
        if (b0.volume !== 16'd2 || b0.amount_due !== 24'd6 || b0.meter_state !== 2'b10 ||
            b0.txn_done !== 1'b1 || b0.dispense_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL shutoff_done: vol=%0d amt=%0d st=%b done=%b en=%b, want 2 6 10 1 0",
                     b0.volume, b0.amount_due, b0.meter_state, b0.txn_done, b0.dispense_enable);
        end
        step();
        n_cmp++;
        if (b0.txn_done !== 1'b0 || b0.meter_state !== 2'b10) begin
            n_bad++;
            $display("FAIL shutoff_pulse_width: done=%b st=%b, want 0 10", b0.txn_done, b0.meter_state);
        end
    endtask

    task automatic test_preset();
        begin_txn(8'd5, 16'd2);
        fuel_out = 1'b1;
        repeat (19) step();
        n_cmp++;
        if (b0.volume !== 16'd1 || b0.dispense_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL preset_before: vol=%0d en=%b, want 1 1", b0.volume, b0.dispense_enable);
        end
        step();
        n_cmp++;
        if (b0.volume !== 16'd2 || b0.amount_due !== 24'd10 || b0.dispense_enable !== 1'b0 ||
            b0.txn_done !== 1'b1) begin
            n_bad++;
            $display("FAIL preset_reached: vol=%0d amt=%0d en=%b done=%b, want 2 10 0 1",
                     b0.volume, b0.amount_due, b0.dispense_enable, b0.txn_done);
        end
        repeat (15) step();
        fuel_out = 1'b0;
        n_cmp++;
        if (b0.volume !== 16'd2 || b0.amount_due !== 24'd10) begin
            n_bad++;
            $display("FAIL preset_hold: vol=%0d amt=%0d, want 2 10", b0.volume, b0.amount_due);
        end
    endtask

    task automatic test_toggle();
        idle_inputs();
        clear = 1'b1;
        step();
        clear = 1'b0; fuel_out = 1'b1;
        repeat (15) step();
        n_cmp++;
        if (b0.volume !== 16'd0 || b0.meter_state !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_ignores_fuel: vol=%0d st=%b, want 0 00", b0.volume, b0.meter_state);
        end
        fuel_out = 1'b0; start = 1'b1; price = 8'd9; preset = 16'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fuel_out = (i % 2 == 0);
            step();
        end
        fuel_out = 1'b0;
        n_cmp++;
        if (b0.volume !== 16'd1 || b0.amount_due !== 24'd9 || b0.meter_state !== 2'b01) begin
            n_bad++;
            $display("FAIL toggle_count: vol=%0d amt=%0d st=%b, want 1 9 01",
                     b0.volume, b0.amount_due, b0.meter_state);
        end
    endtask

    task automatic test_clear_start();
        begin_txn(8'd2, 16'd4);
        fuel_out = 1'b1;
        repeat (40) step();
        fuel_out = 1'b0;
        n_cmp++;
        if (b0.volume !== 16'd4 || b0.amount_due !== 24'd8 || b0.meter_state !== 2'b10) begin
            n_bad++;
            $display("FAIL cs_done: vol=%0d amt=%0d st=%b, want 4 8 10",
                     b0.volume, b0.amount_due, b0.meter_state);
        end
        clear = 1'b1; start = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++;
        if (b0.volume !== 16'd0 || b0.amount_due !== 24'd0 || b0.meter_state !== 2'b00) begin
            n_bad++;
            $display("FAIL cs_clear_wins: vol=%0d amt=%0d st=%b, want 0 0 00",
                     b0.volume, b0.amount_due, b0.meter_state);
        end
        step();
        start = 1'b0;
        n_cmp++;
        if (b0.meter_state !== 2'b01 || b0.dispense_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL cs_restart: st=%b en=%b, want 01 1", b0.meter_state, b0.dispense_enable);
        end
        n_cmp++;
        if (b0.volume !== 16'(m_vol) || b0.amount_due !== 24'(model_amount())) begin
            n_bad++;
            $display("FAIL cs_model: vol=%0d amt=%0d, want %0d %0d",
                     b0.volume, b0.amount_due, m_vol, model_amount());
        end
    endtask

    task automatic test_saturation();
        begin_txn(8'd1, 16'd0);
        fuel_out = 1'b1;
        repeat (150) step();
        n_cmp++;
        if (b1.volume !== 4'd15 || b1.amount_due !== 12'd15 || b1.meter_state !== 2'b10 ||
            b1.txn_done !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_reach: vol=%0d amt=%0d st=%b done=%b, want 15 15 10 1",
                     b1.volume, b1.amount_due, b1.meter_state, b1.txn_done);
        end
        repeat (20) step();
        fuel_out = 1'b0;
        n_cmp++;
        if (b1.volume !== 4'd15 || b1.amount_due !== 12'd15 || b1.meter_state !== 2'b10) begin
            n_bad++;
            $display("FAIL sat_no_wrap: vol=%0d amt=%0d st=%b, want 15 15 10",
                     b1.volume, b1.amount_due, b1.meter_state);
        end
        n_cmp++;
        if (b0.volume !== 16'd17 || b0.meter_state !== 2'b01) begin
            n_bad++;
            $display("FAIL sat_wide_keeps_going: vol=%0d st=%b, want 17 01", b0.volume, b0.meter_state);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            start      = ($urandom_range(0, 24) == 0);
            clear      = ($urandom_range(0, 69) == 0);
            fuel_out   = ($urandom_range(0, 9) < 7);
            pump_state = ($urandom_range(0, 99) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            price      = 8'($urandom_range(0, 255));
            preset     = 16'($urandom_range(0, 4));
            step();
            n_cmp++;
            if (b0.volume !== 16'(m_vol) || b0.amount_due !== 24'(model_amount()) ||
                b0.meter_state !== 2'(m_st) || b0.dispense_enable !== (m_st == 1) ||
                b0.txn_done !== m_done) begin
                n_bad++;
                $display("FAIL random[%0d]: vol=%0d amt=%0d st=%b en=%b done=%b, want %0d %0d %0d %b %b",
                         i, b0.volume, b0.amount_due, b0.meter_state, b0.dispense_enable,
                         b0.txn_done, m_vol, model_amount(), m_st, (m_st == 1), m_done);
            end
        end
        reset_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_shutoff();
        test_preset();
        test_toggle();
        test_clear_start();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
